// File: rtl/proc_param.sv
// proc_param: parametrised multi-cycle bus processor (mv, mvi, add, sub, and, or, mvnz, nop).
// Define PROC_PARAM_FLAGS_EN to add the Carry and Neg flag outputs.
module proc_param #(
    parameter int N     = 9,
    parameter int NREGS = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    output logic         Done,
    output logic [N-1:0] BusWires,
`ifdef PROC_PARAM_FLAGS_EN
    output logic         Carry,
    output logic         Neg,
`endif
    output logic         Zero
);
    localparam int RW = $clog2(NREGS);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [1:0] {S_DIN, S_RY, S_RX, S_G} sel_t;
    state_t state, next;
    sel_t sel;
    logic [N-1:0] r [NREGS];
    logic [N-1:0] a, g, opb, result;
    logic [2:0] op;
    logic [RW-1:0] x, y;
    logic irin, rin, ain, gin, is_alu, is_sub;
    assign is_alu = op[2] ^ op[1];
    assign is_sub = op == 3'b011;
    assign opb = is_sub ? ~BusWires : BusWires;
`ifdef PROC_PARAM_FLAGS_EN
    logic [N:0] sum;
    assign sum = {1'b0, a} + {1'b0, opb} + (N+1)'(is_sub);
`else
    logic [N-1:0] sum;
    assign sum = a + opb + N'(is_sub);
`endif
    assign result = op[2] ? (op[0] ? a | BusWires : a & BusWires) : sum[N-1:0];
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) state <= T0;
        else state <= next;
    always_comb begin
        next = T0;
        case (state)
            T0: next = Run ? T1 : T0;
            T1: next = is_alu ? T2 : T0;
            T2: next = T3;
            default: next = T0;
        endcase
    end
    always_comb begin
        irin = 1'b0;
        rin = 1'b0;
        ain = 1'b0;
        gin = 1'b0;
        Done = 1'b0;
        sel = S_DIN;
        case (state)
            T0: irin = Run;
            T1: begin
                Done = !is_alu;
                ain = is_alu;
                rin = op == 3'b000 || op == 3'b001 || (op == 3'b110 && !Zero);
                sel = is_alu ? S_RX : (op == 3'b000 || op == 3'b110) ? S_RY : S_DIN;
            end
            T2: begin
                sel = S_RY;
                gin = 1'b1;
            end
            default: begin
                sel = S_G;
                rin = 1'b1;
                Done = 1'b1;
            end
        endcase
    end
    always_comb begin
        BusWires = DIN;
        case (sel)
            S_RY: BusWires = r[y];
            S_RX: BusWires = r[x];
            S_G: BusWires = g;
            default: BusWires = DIN;
        endcase
    end
    // Only the opcode and register fields of the instruction are kept.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r <= '{default: '0};
            a <= '0;
            g <= '0;
            op <= '0;
            x <= '0;
            y <= '0;
            Zero <= 1'b0;
`ifdef PROC_PARAM_FLAGS_EN
            Carry <= 1'b0;
            Neg <= 1'b0;
`endif
        end else begin
            if (irin) begin
                op <= DIN[N-1:N-3];
                x <= DIN[2*RW-1:RW];
                y <= DIN[RW-1:0];
            end
            if (rin) r[x] <= BusWires;
            if (ain) a <= BusWires;
            if (gin) begin
                g <= result;
                Zero <= result == '0;
`ifdef PROC_PARAM_FLAGS_EN
                Carry <= !op[2] && sum[N];
                Neg <= result[N-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: directed self-checking bench for proc_param (default 9x8 and a 16x16 instance).
module tb_proc_param;
    logic Clock = 1'b0, Reset = 1'b1, Run = 1'b0, Done, Zero;
    logic [8:0] DIN = 9'h15A, BusWires;
    logic run_w = 1'b0, done_w, zero_w;
    logic [15:0] din_w = '0, bus_w;
    int vec = 0, errs = 0;
`ifdef PROC_PARAM_FLAGS_EN
    logic Carry, Neg, carry_w, neg_w;
`endif
    always #5 Clock = ~Clock;
    proc_param dut (.Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .Done(Done),
        .BusWires(BusWires),
`ifdef PROC_PARAM_FLAGS_EN
        .Carry(Carry), .Neg(Neg),
`endif
        .Zero(Zero));
    proc_param #(.N(16), .NREGS(16)) u_wide (.Clock(Clock), .Reset(Reset), .Run(run_w), .DIN(din_w),
        .Done(done_w), .BusWires(bus_w),
`ifdef PROC_PARAM_FLAGS_EN
        .Carry(carry_w), .Neg(neg_w),
`endif
        .Zero(zero_w));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic [8:0] d);
        @(negedge Clock);
        Run = r;
        DIN = d;
        #1;
    endtask
    task automatic step_w(input logic r, input logic [15:0] d);
        @(negedge Clock);
        run_w = r;
        din_w = d;
        #1;
    endtask
    task automatic mvi(input logic [2:0] x, input logic [8:0] v);
        step(1'b1, {3'b001, x, 3'b000});
        step(1'b0, v);
    endtask
    task automatic peek(input string tag, input logic [2:0] x, input logic [8:0] exp);
        step(1'b1, {3'b000, x, x});
        step(1'b0, 9'h000);
        chk(tag, BusWires, exp);
    endtask
    task automatic alu(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        step(1'b1, {op, x, y});
        repeat (3) step(1'b0, 9'h000);
    endtask
    initial begin
        #1;
        chk("rst_done", Done, 0);
        chk("rst_bus", BusWires, 9'h15A);
        chk("rst_zero", Zero, 0);
        #2 Reset = 1'b0;
        step(1'b1, 9'b001_000_000);
        chk("mvi_t0_done", Done, 0);
        step(1'b0, 9'd5);
        chk("mvi_t1_bus", BusWires, 5);
        chk("mvi_t1_done", Done, 1);
        peek("mvi_r0", 3'd0, 9'd5);
        mvi(3'd1, 9'd7);
        step(1'b1, 9'b010_001_000);
        step(1'b0, 9'h000);
        chk("add_t1_bus", BusWires, 7);
        chk("add_t1_done", Done, 0);
        step(1'b0, 9'h000);
        chk("add_t2_bus", BusWires, 5);
        chk("add_t2_done", Done, 0);
        step(1'b0, 9'h000);
        chk("add_t3_bus", BusWires, 12);
        chk("add_t3_done", Done, 1);
        peek("add_r1", 3'd1, 9'd12);
        chk("add_zero", Zero, 0);
        mvi(3'd2, 9'd3);
        mvi(3'd3, 9'd3);
        alu(3'b011, 3'd2, 3'd3);
        peek("sub_r2", 3'd2, 9'd0);
        chk("sub_zero", Zero, 1);
`ifdef PROC_PARAM_FLAGS_EN
        chk("sub_carry", Carry, 1);
`endif
        mvi(3'd4, 9'd9);
        chk("mvi_keeps_zero", Zero, 1);
        step(1'b1, 9'b110_100_010);
        step(1'b0, 9'h000);
        chk("mvnz_done", Done, 1);
        peek("mvnz_blocked", 3'd4, 9'd9);
        mvi(3'd0, 9'h1FF);
        mvi(3'd1, 9'd1);
        alu(3'b010, 3'd0, 3'd1);
        peek("wrap_r0", 3'd0, 9'd0);
        chk("wrap_zero", Zero, 1);
`ifdef PROC_PARAM_FLAGS_EN
        chk("wrap_carry", Carry, 1);
        chk("wrap_neg", Neg, 0);
`endif
        mvi(3'd5, 9'h0F0);
        mvi(3'd6, 9'h03C);
        alu(3'b100, 3'd5, 3'd6);
        peek("and_r5", 3'd5, 9'h030);
        chk("and_zero", Zero, 0);
`ifdef PROC_PARAM_FLAGS_EN
        chk("and_carry", Carry, 0);
`endif
        step(1'b1, 9'b110_111_101);
        step(1'b0, 9'h000);
        peek("mvnz_taken", 3'd7, 9'h030);
        alu(3'b101, 3'd5, 3'd6);
        peek("or_r5", 3'd5, 9'h03C);
        step(1'b1, 9'b111_101_110);
        step(1'b0, 9'h000);
        chk("nop_done", Done, 1);
        peek("nop_r5", 3'd5, 9'h03C);
        alu(3'b010, 3'd6, 3'd6);
        peek("double_r6", 3'd6, 9'h078);
        step(1'b1, 9'b010_001_001);
        step(1'b0, 9'h0AA);
        step(1'b0, 9'h0AA);
        Reset = 1'b1;
        #1;
        chk("abort_done", Done, 0);
        chk("abort_bus", BusWires, 9'h0AA);
        Reset = 1'b0;
        step(1'b0, 9'h000);
        chk("abort_idle", Done, 0);
        peek("abort_r1", 3'd1, 9'd0);
        mvi(3'd1, 9'd6);
        peek("post_abort", 3'd1, 9'd6);
        step_w(1'b1, 16'h20F0);
        step_w(1'b0, 16'hABCD);
        chk("wide_mvi_done", done_w, 1);
        step_w(1'b1, 16'h000F);
        step_w(1'b0, 16'h0000);
        chk("wide_mv_bus", bus_w, 16'hABCD);
        step_w(1'b1, 16'h0000);
        step_w(1'b0, 16'h0000);
        chk("wide_r0", bus_w, 16'hABCD);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
